// File: rtl/entrada_dados_if.sv
// entrada_dados_if: CPU/user-side bus of the data-input peripheral
//  InRead, Switches, Botao   : driven by the CPU and board (master)
//  Dado, DadoValido, Stall, LEDEspera : driven by the peripheral (slave)
interface entrada_dados_if;
  logic        InRead;
  logic [10:0] Switches;
  logic        Botao;
  logic [31:0] Dado;
  logic        DadoValido;
  logic        Stall;
  logic        LEDEspera;
  modport master (output InRead, Switches, Botao, input Dado, DadoValido, Stall, LEDEspera);
  modport slave  (input InRead, Switches, Botao, output Dado, DadoValido, Stall, LEDEspera);
endinterface

// File: rtl/entrada_dados.sv
// entrada_dados: stalls the CPU on IN until a debounced button press/release, then returns the signed switch value
//  CLK, Reset (async, active-low)
//  bus.InRead/Switches/Botao in; bus.Dado/DadoValido/Stall/LEDEspera out
module entrada_dados #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int MAX_MAG         = 999
) (
  input  logic           CLK,
  input  logic           Reset,
  entrada_dados_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;
  state_t      state_q, state_d;
  logic        btn_s1_q, btn_s2_q, btn_last_q, btn_db_q, btn_db_d;
  logic [10:0] sw_s1_q, sw_s2_q, hold_q, hold_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic        led_q, led_d, valid_q, valid_d;
  logic [31:0] dado_q, dado_d, value;
  logic [9:0]  mag;
  logic        stable, db_done, waiting, blink_wrap;
  always_comb begin
    stable      = btn_s2_q == btn_last_q;
    // a differing level is accepted only after DEBOUNCE_CYCLES stable cycles
    db_done     = stable && btn_s2_q != btn_db_q && db_cnt_q == DW'(DEBOUNCE_CYCLES - 1);
    db_cnt_d    = (!stable || btn_s2_q == btn_db_q || db_done) ? '0 : db_cnt_q + DW'(1);
    btn_db_d    = db_done ? btn_s2_q : btn_db_q;
    mag         = (hold_q[9:0] > 10'(MAX_MAG)) ? 10'(MAX_MAG) : hold_q[9:0];
    value       = hold_q[10] ? -{22'd0, mag} : {22'd0, mag};
    state_d     = state_q;
    hold_d      = hold_q;
    case (state_q)
      IDLE:         state_d = bus.InRead ? (btn_db_q ? WAIT_PRESS : ARM) : IDLE;
      ARM:          state_d = !bus.InRead ? IDLE : (btn_db_q ? WAIT_PRESS : ARM);
      WAIT_PRESS: begin
        state_d = !bus.InRead ? IDLE : (!btn_db_q ? WAIT_RELEASE : WAIT_PRESS);
        hold_d  = (bus.InRead && !btn_db_q) ? sw_s2_q : hold_q;
      end
      WAIT_RELEASE: state_d = !bus.InRead ? IDLE : (btn_db_q ? DONE : WAIT_RELEASE);
      default:      state_d = IDLE;
    endcase
    valid_d     = state_d == DONE;
    dado_d      = valid_d ? value : dado_q;
    // LED follows the next state so it is already 0 during the DONE cycle
    waiting     = state_d inside {ARM, WAIT_PRESS, WAIT_RELEASE};
    blink_wrap  = blink_cnt_q == BW'(BLINK_CYCLES - 1);
    blink_cnt_d = (waiting && !blink_wrap) ? blink_cnt_q + BW'(1) : '0;
    led_d       = waiting ? (blink_wrap ? ~led_q : led_q) : 1'b0;
  end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      btn_s1_q    <= 1'b1;
      btn_s2_q    <= 1'b1;
      btn_last_q  <= 1'b1;
      btn_db_q    <= 1'b1;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      hold_q      <= '0;
      db_cnt_q    <= '0;
      blink_cnt_q <= '0;
      led_q       <= 1'b0;
      valid_q     <= 1'b0;
      dado_q      <= '0;
    end else begin
      state_q     <= state_d;
      btn_s1_q    <= bus.Botao;
      btn_s2_q    <= btn_s1_q;
      btn_last_q  <= btn_s2_q;
      btn_db_q    <= btn_db_d;
      sw_s1_q     <= bus.Switches;
      sw_s2_q     <= sw_s1_q;
      hold_q      <= hold_d;
      db_cnt_q    <= db_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      led_q       <= led_d;
      valid_q     <= valid_d;
      dado_q      <= dado_d;
    end
  end
  assign bus.Stall      = bus.InRead & (state_q != DONE) & Reset;
  assign bus.Dado       = dado_q;
  assign bus.DadoValido = valid_q;
  assign bus.LEDEspera  = led_q;
endmodule
